register_file_vector_serial: RTL and testbench

//  Parametrised vector register file for the SIMD AES datapath. Two async full-width read ports
//  and one full-width write port serve decode/writeback. Adds a lane-serial LANE_W port that

---
 rtl/vrf_pkg.sv | 21 ++
 rtl/vrf_lane_serializer.sv | 110 +++++++++++
 rtl/register_file_vector_serial.sv | 83 ++++++++
 tb/tb_register_file_vector_serial.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared constants and serial-port state type for the vector register file
package vrf_pkg;
    localparam int VLEN         = 256;
    localparam int LANE_W       = 32;
    localparam int NREGS        = 8;
    localparam int RA_W         = 5;
    localparam int NBEATS       = VLEN / LANE_W;
    localparam int REG_W        = $clog2(NREGS);
    localparam int CNT_W        = $clog2(NBEATS);
    localparam int VEC_FLAG_BIT = RA_W - 1;

    // Reads outside vector space return this marker pattern
    localparam logic [VLEN-1:0] NON_VEC_READ = {{(VLEN-32){1'b0}}, 32'hFFFF_FFFF};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        STORE  = 2'd3
    } ser_state_t;
endpackage

// File: rtl/vrf_lane_serializer.sv
// rtl/vrf_lane_serializer.sv - lane-serial load/store engine with shadow buffer and atomic commit
module vrf_lane_serializer
    import vrf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_start,
    input  logic              ser_dir,
    input  logic [REG_W-1:0]  ser_reg,
    input  logic              ser_in_valid,
    input  logic [LANE_W-1:0] ser_in_data,
    output logic              ser_in_ready,
    output logic              ser_out_valid,
    output logic [LANE_W-1:0] ser_out_data,
    input  logic              ser_out_ready,
    output logic              ser_busy,
    output logic              ser_done,
    input  logic [VLEN-1:0]   snap_data,
    output logic              commit_en,
    output logic [REG_W-1:0]  commit_reg,
    output logic [VLEN-1:0]   commit_data
);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    ser_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [REG_W-1:0]  reg_q;
    logic [VLEN-1:0]   shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Loads assemble in the shadow so the target is untouched until COMMIT;
    // stores read from a snapshot so later array writes cannot leak into the beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            reg_q  <= '0;
            shadow <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ser_start) begin
                        cnt   <= '0;
                        reg_q <= ser_reg;
                        if (ser_dir) begin
                            shadow <= snap_data;
                        end
                    end
                end
                LOAD: begin
                    if (ser_in_valid) begin
                        shadow[cnt*LANE_W +: LANE_W] <= ser_in_data;
                        cnt <= cnt + 1'b1;
                    end
                end
                STORE: begin
                    if (ser_out_ready) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        ser_in_ready  = 1'b0;
        ser_out_valid = 1'b0;
        ser_done      = 1'b0;
        commit_en     = 1'b0;
        case (state)
            IDLE: begin
                if (ser_start) begin
                    state_next = ser_dir ? STORE : LOAD;
                end
            end
            LOAD: begin
                ser_in_ready = 1'b1;
                if (ser_in_valid && cnt == LAST_BEAT) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit_en  = 1'b1;
                ser_done   = 1'b1;
                state_next = IDLE;
            end
            STORE: begin
                ser_out_valid = 1'b1;
                if (ser_out_ready && cnt == LAST_BEAT) begin
                    ser_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ser_out_data = shadow[cnt*LANE_W +: LANE_W];
    assign ser_busy     = (state != IDLE);
    assign commit_reg   = reg_q;
    assign commit_data  = shadow;
endmodule

// File: rtl/register_file_vector_serial.sv
// rtl/register_file_vector_serial.sv - vector register file with two read ports, one write port and a lane-serial port
module register_file_vector_serial
    import vrf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   VA1,
    input  logic [RA_W-1:0]   VA2,
    input  logic [RA_W-1:0]   VA3,
    input  logic [VLEN-1:0]   VWD3,
    input  logic              VWE3,
    output logic [VLEN-1:0]   VRD1,
    output logic [VLEN-1:0]   VRD2,
    input  logic              ser_start,
    input  logic              ser_dir,
    input  logic [REG_W-1:0]  ser_reg,
    input  logic              ser_in_valid,
    input  logic [LANE_W-1:0] ser_in_data,
    output logic              ser_in_ready,
    output logic              ser_out_valid,
    output logic [LANE_W-1:0] ser_out_data,
    input  logic              ser_out_ready,
    output logic              ser_busy,
    output logic              ser_done,
    output logic              wr_conflict
);
    logic [VLEN-1:0]  regs [NREGS];
    logic [REG_W-1:0] wr_idx;
    logic [VLEN-1:0]  snap_data;
    logic             commit_en;
    logic [REG_W-1:0] commit_reg;
    logic [VLEN-1:0]  commit_data;
    logic             unused_addr_bits;

    assign wr_idx = VA3[REG_W-1:0];

    // Forward a same-cycle full write so a store snapshot sees the newest value
    assign snap_data = (VWE3 && wr_idx == ser_reg) ? VWD3 : regs[ser_reg];

    vrf_lane_serializer u_ser (
        .clk           (clk),
        .rst           (rst),
        .ser_start     (ser_start),
        .ser_dir       (ser_dir),
        .ser_reg       (ser_reg),
        .ser_in_valid  (ser_in_valid),
        .ser_in_data   (ser_in_data),
        .ser_in_ready  (ser_in_ready),
        .ser_out_valid (ser_out_valid),
        .ser_out_data  (ser_out_data),
        .ser_out_ready (ser_out_ready),
        .ser_busy      (ser_busy),
        .ser_done      (ser_done),
        .snap_data     (snap_data),
        .commit_en     (commit_en),
        .commit_reg    (commit_reg),
        .commit_data   (commit_data)
    );

    // Commit is written last so it wins a same-register collision with VWE3
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (VWE3) begin
                regs[wr_idx] <= VWD3;
            end
            if (commit_en) begin
                regs[commit_reg] <= commit_data;
            end
        end
    end

    assign wr_conflict = commit_en && VWE3 && (wr_idx == commit_reg);

    assign VRD1 = VA1[VEC_FLAG_BIT] ? regs[VA1[REG_W-1:0]] : NON_VEC_READ;
    assign VRD2 = VA2[VEC_FLAG_BIT] ? regs[VA2[REG_W-1:0]] : NON_VEC_READ;

    // Address bits above the register index select nothing in this array
    assign unused_addr_bits = ^{VA1[RA_W-2:REG_W], VA2[RA_W-2:REG_W], VA3[RA_W-1:REG_W]};
endmodule

// File: tb/tb_register_file_vector_serial.sv
// tb/tb_register_file_vector_serial.sv - directed self-checking bench for register_file_vector_serial
module tb_register_file_vector_serial;
    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   VA1, VA2, VA3;
    logic [255:0] VWD3;
    logic         VWE3;
    logic [255:0] VRD1, VRD2;
    logic         ser_start, ser_dir;
    logic [2:0]   ser_reg;
    logic         ser_in_valid;
    logic [31:0]  ser_in_data;
    logic         ser_in_ready, ser_out_valid;
    logic [31:0]  ser_out_data;
    logic         ser_out_ready;
    logic         ser_busy, ser_done, wr_conflict;

    int passed = 0;
    int total  = 0;

    logic [255:0] load_vec, a_vec, v5, v5_new, non_vec, r6_vec;
    logic [31:0]  exp_beat;

    always #5 clk = ~clk;

    register_file_vector_serial dut (
        .clk           (clk),
        .rst           (rst),
        .VA1           (VA1),
        .VA2           (VA2),
        .VA3           (VA3),
        .VWD3          (VWD3),
        .VWE3          (VWE3),
        .VRD1          (VRD1),
        .VRD2          (VRD2),
        .ser_start     (ser_start),
        .ser_dir       (ser_dir),
        .ser_reg       (ser_reg),
        .ser_in_valid  (ser_in_valid),
        .ser_in_data   (ser_in_data),
        .ser_in_ready  (ser_in_ready),
        .ser_out_valid (ser_out_valid),
        .ser_out_data  (ser_out_data),
        .ser_out_ready (ser_out_ready),
        .ser_busy      (ser_busy),
        .ser_done      (ser_done),
        .wr_conflict   (wr_conflict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        load_vec = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
        a_vec    = 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0;
        r6_vec   = 256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100;
        v5       = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        v5_new   = 256'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        non_vec  = {224'h0, 32'hFFFF_FFFF};

        // Reset with a write pending
        rst = 1'b0; VA1 = 5'h11; VA2 = 5'h17; VA3 = 5'h11; VWD3 = '1; VWE3 = 1'b1;
        ser_start = 1'b0; ser_dir = 1'b0; ser_reg = 3'd0; ser_in_valid = 1'b0;
        ser_in_data = '0; ser_out_ready = 1'b0;
        tick(); tick();
        settle();
        chk("rst_vrd1", VRD1, '0);
        chk("rst_busy", ser_busy, 0);
        chk("rst_in_ready", ser_in_ready, 0);
        chk("rst_out_valid", ser_out_valid, 0);
        chk("rst_done", ser_done, 0);
        chk("rst_conflict", wr_conflict, 0);
        rst = 1'b1; VWE3 = 1'b0;
        tick(); settle();
        chk("post_rst_vrd1", VRD1, '0);
        chk("post_rst_vrd2", VRD2, '0);

        // Load beats 0..7 into reg3
        ser_start = 1'b1; ser_dir = 1'b0; ser_reg = 3'd3; VA1 = 5'h13;
        tick();
        ser_start = 1'b0;
        settle();
        chk("load_busy", ser_busy, 1);
        chk("load_in_ready", ser_in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            ser_in_valid = 1'b1; ser_in_data = 32'(k);
            if (k == 7) begin
                settle();
                chk("load_old_before_last", VRD1, '0);
            end
            tick();
        end
        ser_in_valid = 1'b0;
        settle();
        chk("load_commit_done", ser_done, 1);
        chk("load_old_in_commit", VRD1, '0);
        chk("load_commit_in_ready", ser_in_ready, 0);
        tick(); settle();
        chk("load_result", VRD1, load_vec);
        chk("load_done_clear", ser_done, 0);
        chk("load_idle", ser_busy, 0);

        // Store reg5 with backpressure and a mid-store overwrite
        VWE3 = 1'b1; VA3 = 5'h15; VWD3 = v5;
        tick();
        VWE3 = 1'b0;
        ser_start = 1'b1; ser_dir = 1'b1; ser_reg = 3'd5; ser_out_ready = 1'b0;
        tick();
        ser_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_beat = v5[k*32 +: 32];
            settle();
            chk("store_valid", ser_out_valid, 1);
            chk("store_beat", ser_out_data, exp_beat);
            tick(); settle();
            chk("store_beat_stalled", ser_out_data, exp_beat);
            ser_out_ready = 1'b1;
            if (k == 3) begin
                VWE3 = 1'b1; VA3 = 5'h15; VWD3 = v5_new;
            end
            if (k == 7) begin
                settle();
                chk("store_last_done", ser_done, 1);
            end
            tick();
            ser_out_ready = 1'b0; VWE3 = 1'b0;
        end
        settle();
        chk("store_idle", ser_busy, 0);
        chk("store_done_clear", ser_done, 0);
        VA1 = 5'h15;
        settle();
        chk("store_overwrite_applied", VRD1, v5_new);

        // Same-register collision in the commit cycle
        ser_start = 1'b1; ser_dir = 1'b0; ser_reg = 3'd3;
        tick();
        ser_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ser_in_valid = 1'b1; ser_in_data = 32'hA0 + 32'(k);
            tick();
        end
        ser_in_valid = 1'b0;
        VWE3 = 1'b1; VA3 = 5'h13; VWD3 = '1;
        settle();
        chk("conflict_pulse", wr_conflict, 1);
        chk("conflict_done", ser_done, 1);
        tick();
        VWE3 = 1'b0; VA1 = 5'h13;
        settle();
        chk("conflict_clear", wr_conflict, 0);
        chk("conflict_commit_wins", VRD1, a_vec);

        // Non-vector read and start while busy
        VA2 = 5'h03;
        settle();
        chk("non_vec_read", VRD2, non_vec);
        ser_start = 1'b1; ser_dir = 1'b0; ser_reg = 3'd6;
        tick();
        ser_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ser_in_valid = 1'b1; ser_in_data = 32'h55 + 32'(k);
            if (k == 1) begin
                ser_start = 1'b1; ser_dir = 1'b1; ser_reg = 3'd2;
            end
            tick();
            ser_start = 1'b0;
            settle();
            chk("busy_start_ignored_in_ready", ser_in_ready, 1);
            chk("busy_start_ignored_out_valid", ser_out_valid, 0);
        end

        // Abort after four beats
        ser_in_valid = 1'b0;
        rst = 1'b0;
        VA1 = 5'h16; VA2 = 5'h13;
        settle();
        chk("abort_busy", ser_busy, 0);
        chk("abort_in_ready", ser_in_ready, 0);
        chk("abort_reg6", VRD1, '0);
        chk("abort_reg3_cleared", VRD2, '0);
        tick();
        rst = 1'b1;
        tick();
        settle();
        chk("abort_reg6_after_release", VRD1, '0);

        // Fresh load after abort
        ser_start = 1'b1; ser_dir = 1'b0; ser_reg = 3'd6;
        tick();
        ser_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ser_in_valid = 1'b1; ser_in_data = 32'h100 + 32'(k);
            tick();
        end
        ser_in_valid = 1'b0;
        settle();
        chk("reload_done", ser_done, 1);
        tick(); settle();
        chk("reload_result", VRD1, r6_vec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
